i2c_txn_sequencer: RTL and testbench

//  Multi-client I2C transaction sequencer between peripheral clients (touch panel, RTC, ...) and the byte-level I2C master.

---
 rtl/i2c_txn_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_i2c_txn_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_sequencer.sv
// Purpose : peripheral reset/init, then round-robin arbitration of N_CH clients onto a byte-level I2C master.
// Latency : req seen in IDLE -> enI2C high 2 cycles later; one register-pointer byte then LEN data bytes.
// Backpressure: clients hold req until done/err; each byte waits on the master's busy handshake (bounded by TIMEOUT_CYC).
// Ports: clk/reset (async active-low); per-channel req/req_rw/req_dev/req_reg/req_len/wr_data in;
//        gnt/done/err per channel, wr_take, rd_data/rd_valid/rd_idx, ready out;
//        master side enI2C/rw/address/data out, dataIn/busy in; resetPeriph open-drain (0 or Z).
module i2c_txn_sequencer #(
   parameter  int N_CH         = 2,
   parameter  int MAX_LEN      = 8,
   parameter  int RST_LOW_CYC  = 8000,
   parameter  int RST_WAIT_CYC = 48000,
   parameter  int TIMEOUT_CYC  = 65535,
   localparam int LW           = $clog2(MAX_LEN + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   req,
   input  logic [N_CH-1:0]   req_rw,
   input  logic [N_CH*7-1:0] req_dev,
   input  logic [N_CH*8-1:0] req_reg,
   input  logic [N_CH*LW-1:0] req_len,
   input  logic [N_CH*8-1:0] wr_data,
   output logic [N_CH-1:0]   gnt,
   output logic              wr_take,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   output logic [LW-1:0]     rd_idx,
   output logic [N_CH-1:0]   done,
   output logic [N_CH-1:0]   err,
   output logic              ready,
   output logic              enI2C,
   output logic              rw,
   output logic [6:0]        address,
   output logic [7:0]        data,
   input  logic [7:0]        dataIn,
   input  logic              busy,
   inout  wire               resetPeriph
);

   localparam int CMAX0 = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
   localparam int CMAX  = (CMAX0 > TIMEOUT_CYC) ? CMAX0 : TIMEOUT_CYC;
   localparam int CW    = $clog2(CMAX + 1);
   localparam int PW    = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic [2:0] {
      S_INIT_RST, S_INIT_WAIT, S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_FINISH
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;        // shared: init phase timer and per-byte timeout
   logic            rp_drv_q;
   logic            ready_q;
   logic [PW-1:0]   rr_q;
   logic [PW-1:0]   g_q;
   logic [6:0]      dev_q;
   logic [7:0]      reg_q;
   logic [LW-1:0]   len_q;
   logic            rw_l_q;
   logic [LW:0]     bcnt_q;       // bytes issued so far, including the pointer byte
   logic [N_CH-1:0] gnt_q, done_q, err_q;
   logic            wr_take_q, rd_valid_q, en_q, rw_q;
   logic [7:0]      rd_data_q, data_q;
   logic [LW-1:0]   rd_idx_q;
   logic [6:0]      addr_q;
   logic            bsy_meta_q, bsy_s_q, bsy_prev_q;

   logic [PW-1:0]   arb_idx_d;
   logic            arb_vld_d;
   logic [LW-1:0]   sel_len_d;
   logic            bad_len_d;
   logic            bsy_rise, bsy_fall, tmo;

   assign resetPeriph = rp_drv_q ? 1'b0 : 1'bz;

   assign bsy_rise = bsy_s_q & ~bsy_prev_q;
   assign bsy_fall = ~bsy_s_q & bsy_prev_q;
   assign tmo      = (cnt_q == CW'(TIMEOUT_CYC - 1));

   // Search from rr_q+1 upward with wrap; iterating the farthest offset first
   // lets the nearest requesting channel overwrite and win.
   always_comb begin
      arb_idx_d = '0;
      arb_vld_d = 1'b0;
      for (int i = N_CH; i >= 1; i--) begin
         if (req[(int'(rr_q) + i) % N_CH]) begin
            arb_idx_d = PW'((int'(rr_q) + i) % N_CH);
            arb_vld_d = 1'b1;
         end
      end
   end

   always_comb begin
      sel_len_d = req_len[int'(arb_idx_d)*LW +: LW];
      bad_len_d = (sel_len_d == '0) || (int'(sel_len_d) > MAX_LEN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_INIT_RST;
         cnt_q      <= '0;
         rp_drv_q   <= 1'b1;
         ready_q    <= 1'b0;
         rr_q       <= PW'(N_CH - 1);
         g_q        <= '0;
         dev_q      <= '0;
         reg_q      <= '0;
         len_q      <= '0;
         rw_l_q     <= 1'b0;
         bcnt_q     <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         err_q      <= '0;
         wr_take_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_idx_q   <= '0;
         en_q       <= 1'b0;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         bsy_meta_q <= 1'b0;
         bsy_s_q    <= 1'b0;
         bsy_prev_q <= 1'b0;
      end else begin
         bsy_meta_q <= busy;
         bsy_s_q    <= bsy_meta_q;
         bsy_prev_q <= bsy_s_q;
         wr_take_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         done_q     <= '0;
         err_q      <= '0;
         case (state_q)
            S_INIT_RST: begin
               if (cnt_q == CW'(RST_LOW_CYC - 1)) begin
                  cnt_q    <= '0;
                  rp_drv_q <= 1'b0;
                  state_q  <= S_INIT_WAIT;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_INIT_WAIT: begin
               if (cnt_q == CW'(RST_WAIT_CYC - 1)) begin
                  cnt_q   <= '0;
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            // IDLE is only reachable after init, so requests are held off until ready.
            S_IDLE: begin
               if (arb_vld_d) begin
                  rr_q   <= arb_idx_d;
                  g_q    <= arb_idx_d;
                  dev_q  <= req_dev[int'(arb_idx_d)*7 +: 7];
                  reg_q  <= req_reg[int'(arb_idx_d)*8 +: 8];
                  len_q  <= sel_len_d;
                  rw_l_q <= req_rw[arb_idx_d];
                  bcnt_q <= '0;
                  if (bad_len_d) begin
                     err_q[arb_idx_d] <= 1'b1;
                  end else begin
                     gnt_q   <= N_CH'(1) << arb_idx_d;
                     state_q <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               en_q   <= 1'b1;
               addr_q <= dev_q;
               if (bcnt_q == '0) begin
                  rw_q   <= 1'b0;
                  data_q <= reg_q;
               end else begin
                  rw_q <= rw_l_q;
                  if (!rw_l_q) begin
                     data_q    <= wr_data[int'(g_q)*8 +: 8];
                     wr_take_q <= 1'b1;
                  end
               end
               bcnt_q  <= bcnt_q + 1'b1;
               cnt_q   <= '0;
               state_q <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (bsy_rise) begin
                  en_q    <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= S_WAIT_DONE;
               end else if (tmo) begin
                  en_q       <= 1'b0;
                  err_q[g_q] <= 1'b1;
                  gnt_q      <= '0;
                  state_q    <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_WAIT_DONE: begin
               if (bsy_fall) begin
                  // Byte 0 is the register pointer, so data byte k is bcnt_q == k+2.
                  if (rw_l_q && (bcnt_q > (LW+1)'(1))) begin
                     rd_data_q  <= dataIn;
                     rd_idx_q   <= LW'(bcnt_q - (LW+1)'(2));
                     rd_valid_q <= 1'b1;
                  end
                  if (bcnt_q == ({1'b0, len_q} + (LW+1)'(1))) state_q <= S_FINISH;
                  else                                         state_q <= S_ISSUE;
               end else if (tmo) begin
                  err_q[g_q] <= 1'b1;
                  gnt_q      <= '0;
                  state_q    <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_FINISH: begin
               done_q[g_q] <= 1'b1;
               gnt_q       <= '0;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_INIT_RST;
         endcase
      end
   end

   assign gnt      = gnt_q;
   assign wr_take  = wr_take_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign rd_idx   = rd_idx_q;
   assign done     = done_q;
   assign err      = err_q;
   assign ready    = ready_q;
   assign enI2C    = en_q;
   assign rw       = rw_q;
   assign address  = addr_q;
   assign data     = data_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Purpose : scoreboard bench for i2c_txn_sequencer with a behavioural byte-level I2C master.
// Latency : init phases shortened (80/480 cycles) and timeout set to 100 so two init runs fit the budget.
// Backpressure: master model answers each enI2C with a busy pulse unless muted for the timeout case.
module tb_i2c_txn_sequencer;

   localparam int N_CH  = 2;
   localparam int MAXL  = 8;
   localparam int LW    = 4;
   localparam int RLOW  = 80;
   localparam int RWAIT = 480;
   localparam int TMO   = 100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset   = 1'b0;
   logic [1:0]  req     = '0;
   logic [1:0]  req_rw  = '0;
   logic [13:0] req_dev = '0;
   logic [15:0] req_reg = '0;
   logic [7:0]  req_len = '0;
   logic [15:0] wr_data = '0;
   logic [7:0]  dataIn  = '0;
   logic        busy    = 1'b0;
   logic [1:0]  gnt, done, err;
   logic        wr_take, rd_valid, ready, enI2C, rw;
   logic [7:0]  rd_data, data;
   logic [3:0]  rd_idx;
   logic [6:0]  address;
   wire         resetPeriph;
   pullup (resetPeriph);

   i2c_txn_sequencer #(.N_CH(N_CH), .MAX_LEN(MAXL), .RST_LOW_CYC(RLOW),
                       .RST_WAIT_CYC(RWAIT), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_dev(req_dev),
      .req_reg(req_reg), .req_len(req_len), .wr_data(wr_data), .gnt(gnt),
      .wr_take(wr_take), .rd_data(rd_data), .rd_valid(rd_valid), .rd_idx(rd_idx),
      .done(done), .err(err), .ready(ready), .enI2C(enI2C), .rw(rw),
      .address(address), .data(data), .dataIn(dataIn), .busy(busy),
      .resetPeriph(resetPeriph));

   typedef struct packed {
      logic       rw;
      logic [6:0] addr;
      logic [7:0] dat;
      logic       chk_dat;
   } bus_t;

   bus_t       exp_bus[$];
   logic [11:0] exp_rd[$];
   logic [3:0] exp_evt[$];
   logic [1:0] exp_gnt[$];
   logic [7:0] mst_rd[$];
   logic [7:0] wr0_q[$];
   logic [7:0] wr1_q[$];

   int checks = 0, failures = 0;
   int gnt_cnt = 0, wr_take_cnt = 0, rd_cnt = 0;
   logic mute = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   // Output monitor: done/err events, read bytes, grants, write-byte feed.
   initial begin
      logic [1:0] prev_gnt;
      prev_gnt = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_gnt = '0;
         end else begin
            if ((done | err) != '0) begin
               if (exp_evt.size() == 0) chk("evt_unexpected", {err, done}, 0);
               else                     chk("evt", {err, done}, exp_evt.pop_front());
            end
            if (rd_valid) begin
               rd_cnt++;
               if (exp_rd.size() == 0) chk("rd_unexpected", {rd_idx, rd_data}, 0);
               else                    chk("rd", {rd_idx, rd_data}, exp_rd.pop_front());
            end
            if (gnt != '0 && gnt != prev_gnt) begin
               gnt_cnt++;
               if (exp_gnt.size() == 0) chk("gnt_unexpected", gnt, 0);
               else                     chk("gnt", gnt, exp_gnt.pop_front());
            end
            prev_gnt = gnt;
            if (wr_take) begin
               wr_take_cnt++;
               if (gnt[0] && wr0_q.size() > 0) void'(wr0_q.pop_front());
               if (gnt[1] && wr1_q.size() > 0) void'(wr1_q.pop_front());
            end
         end
         wr_data = {(wr1_q.size() > 0) ? wr1_q[0] : 8'h00,
                    (wr0_q.size() > 0) ? wr0_q[0] : 8'h00};
      end
   end

   // Behavioural I2C byte master; also checks each issued byte against the scoreboard.
   initial begin
      bus_t e;
      logic cur_rw;
      int   n;
      forever begin
         @(negedge clk);
         if (enI2C) begin
            cur_rw = rw;
            if (exp_bus.size() == 0) begin
               chk("bus_unexpected", enI2C, 0);
            end else begin
               e = exp_bus.pop_front();
               chk("bus_rw_addr", {rw, address}, {e.rw, e.addr});
               if (e.chk_dat) chk("bus_data", data, e.dat);
            end
            if (!mute) begin
               repeat (2) @(negedge clk);
               busy = 1'b1;
            end
            n = 0;
            while (enI2C && n < 300) begin
               @(negedge clk);
               n++;
            end
            if (n >= 300) chk("mst_en_release", enI2C, 0);
            if (!mute) begin
               repeat (3) @(negedge clk);
               if (cur_rw) dataIn = (mst_rd.size() > 0) ? mst_rd.pop_front() : 8'h00;
               @(negedge clk);
               busy = 1'b0;
            end
         end
      end
   end

   task automatic start(input int ch, input logic r, input logic [6:0] dev,
                        input logic [7:0] rg, input logic [3:0] len);
      req_rw[ch]            = r;
      req_dev[ch*7 +: 7]    = dev;
      req_reg[ch*8 +: 8]    = rg;
      req_len[ch*LW +: LW]  = len;
      req[ch]               = 1'b1;
   endtask

   task automatic wait_evt(input int ch, input string nm);
      int n;
      n = 0;
      while (!(done[ch] | err[ch]) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) chk({nm, "_evt_timeout"}, done[ch] | err[ch], 1);
      req[ch] = 1'b0;
   endtask

   task automatic init_check(input string nm);
      int n;
      n = 0;
      while (resetPeriph === 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk_rng({nm, "_rst_low_cycles"}, n, RLOW - 1, RLOW + 1);
      chk({nm, "_periph_released"}, int'(resetPeriph), 1);
      n = 0;
      while (!ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk_rng({nm, "_ready_cycles"}, n, RWAIT - 1, RWAIT + 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, base, wt0;
      logic en_seen;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ready", ready, 0);
      chk("rst_periph", int'(resetPeriph), 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_en", enI2C, 0);
      reset = 1'b1;
      init_check("init");

      // Read ch0: dev 0x38, reg 0x02, len 3, master returns A1,B2,C3
      exp_bus.push_back('{1'b0, 7'h38, 8'h02, 1'b1});
      repeat (3) exp_bus.push_back('{1'b1, 7'h38, 8'h00, 1'b0});
      mst_rd = '{8'hA1, 8'hB2, 8'hC3};
      exp_rd = '{{4'd0, 8'hA1}, {4'd1, 8'hB2}, {4'd2, 8'hC3}};
      exp_gnt.push_back(2'b01);
      exp_evt.push_back(4'b0001);
      start(0, 1'b1, 7'h38, 8'h02, 4'd3);
      wait_evt(0, "read");

      // Write ch1: dev 0x68, reg 0x00, bytes 0x45, 0x12
      wr1_q = '{8'h45, 8'h12};
      @(negedge clk);
      exp_bus.push_back('{1'b0, 7'h68, 8'h00, 1'b1});
      exp_bus.push_back('{1'b0, 7'h68, 8'h45, 1'b1});
      exp_bus.push_back('{1'b0, 7'h68, 8'h12, 1'b1});
      exp_gnt.push_back(2'b10);
      exp_evt.push_back(4'b0010);
      wt0 = wr_take_cnt;
      start(1, 1'b0, 7'h68, 8'h00, 4'd2);
      wait_evt(1, "write");
      chk("write_wr_take_count", wr_take_cnt - wt0, 2);

      // Round robin with both requests held: ch0, ch1, ch0
      wr0_q = '{8'h55, 8'h55};
      wr1_q = '{8'h66};
      @(negedge clk);
      exp_bus.push_back('{1'b0, 7'h11, 8'hA0, 1'b1});
      exp_bus.push_back('{1'b0, 7'h11, 8'h55, 1'b1});
      exp_bus.push_back('{1'b0, 7'h22, 8'hB0, 1'b1});
      exp_bus.push_back('{1'b0, 7'h22, 8'h66, 1'b1});
      exp_bus.push_back('{1'b0, 7'h11, 8'hA0, 1'b1});
      exp_bus.push_back('{1'b0, 7'h11, 8'h55, 1'b1});
      exp_gnt = '{2'b01, 2'b10, 2'b01};
      exp_evt = '{4'b0001, 4'b0010, 4'b0001};
      base = gnt_cnt;
      wt0  = wr_take_cnt;
      req_rw[1] = 1'b0; req_dev[13:7] = 7'h22; req_reg[15:8] = 8'hB0; req_len[7:4] = 4'd1;
      start(0, 1'b0, 7'h11, 8'hA0, 4'd1);
      req[1] = 1'b1;
      n = 0;
      while (gnt_cnt < base + 3 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("rr_grant_count", gnt_cnt - base, 3);
      req = '0;
      n = 0;
      while (exp_evt.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("rr_events_left", exp_evt.size(), 0);
      chk("rr_wr_take_count", wr_take_cnt - wt0, 3);

      // Timeout: master never raises busy
      mute = 1'b1;
      wr0_q = '{8'h77};
      @(negedge clk);
      exp_bus.push_back('{1'b0, 7'h10, 8'h20, 1'b1});
      exp_gnt.push_back(2'b01);
      exp_evt.push_back(4'b0100);
      start(0, 1'b0, 7'h10, 8'h20, 4'd1);
      n = 0;
      while (!enI2C && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_en_rise", enI2C, 1);
      n = 0;
      while (!err[0] && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk_rng("tmo_cycles", n, TMO - 2, TMO + 2);
      chk("tmo_en_low", enI2C, 0);
      chk("tmo_gnt_low", gnt, 0);
      req[0] = 1'b0;
      repeat (5) @(negedge clk);
      mute = 1'b0;
      wr0_q.delete();

      // Bad lengths: 0 on ch1, MAX_LEN+1 on ch0; no bus activity either way
      en_seen = 1'b0;
      exp_evt.push_back(4'b1000);
      start(1, 1'b0, 7'h33, 8'h44, 4'd0);
      wait_evt(1, "badlen0");
      exp_evt.push_back(4'b0100);
      start(0, 1'b1, 7'h33, 8'h44, 4'd9);
      wait_evt(0, "badlen9");
      repeat (20) begin
         @(negedge clk);
         if (enI2C) en_seen = 1'b1;
      end
      chk("badlen_no_en", en_seen, 0);
      chk("badlen_events_left", exp_evt.size(), 0);

      // Reset in the middle of a read
      exp_bus.push_back('{1'b0, 7'h38, 8'h05, 1'b1});
      repeat (3) exp_bus.push_back('{1'b1, 7'h38, 8'h00, 1'b0});
      mst_rd = '{8'h5A, 8'h6B, 8'h7C};
      exp_rd = '{{4'd0, 8'h5A}, {4'd1, 8'h6B}, {4'd2, 8'h7C}};
      exp_gnt.push_back(2'b01);
      base = rd_cnt;
      start(0, 1'b1, 7'h38, 8'h05, 4'd3);
      n = 0;
      while (rd_cnt == base && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("midrd_first_byte", rd_cnt - base, 1);
      reset = 1'b0;
      req   = '0;
      #1;
      chk("midrd_gnt", gnt, 0);
      chk("midrd_en", enI2C, 0);
      chk("midrd_ready", ready, 0);
      chk("midrd_periph", int'(resetPeriph), 0);
      exp_bus.delete(); exp_rd.delete(); exp_evt.delete(); exp_gnt.delete(); mst_rd.delete();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      init_check("reinit");
      chk("final_bus_left", exp_bus.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
